// File: rtl/multicyc_exec_ctrl.sv
// HI/LO multiply/divide sequencer. Multiplies finish after MUL_CYCLES, divides after 35 cycles (2 for trivial divides with MULTICYC_DIV_FASTPATH_EN).
// The result is held in DONE until resp_ack so EX stalls; flush aborts from any state.
package multicyc_exec_pkg;
  typedef enum logic [3:0] {
    OP_NOP, OP_MULT, OP_MULTU, OP_MADD, OP_MADDU,
    OP_MSUB, OP_MSUBU, OP_MUL, OP_DIV, OP_DIVU
  } mc_op_e;

  typedef struct packed {
    mc_op_e      op;
    logic        is_multicyc;
    logic [63:0] hilo;
    logic [31:0] reg0;
    logic [31:0] reg1;
  } multicyc_req_t;

  typedef struct packed {
    logic        ready;
    logic        valid;
    logic [63:0] hilo;
  } multicyc_resp_t;
endpackage

module multicyc_exec_ctrl
  import multicyc_exec_pkg::*;
#(
  parameter int MUL_CYCLES = 3,
  parameter int DIV_ITERS  = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  input  multicyc_req_t  req,
  input  logic           resp_ack,
  output multicyc_resp_t resp,
  output logic           busy
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_MUL, ST_DIV_PREP, ST_DIV_ITER, ST_DIV_FIX, ST_DONE
  } state_e;

  localparam logic [7:0] MUL_LAST = 8'(MUL_CYCLES - 2);
  localparam logic [7:0] DIV_LAST = 8'(DIV_ITERS - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  mc_op_e      op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [63:0] hilo_q, hilo_d;
  logic [63:0] result_q, result_d;
  logic [31:0] quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic        quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

  // Multiplier operands come straight from req in IDLE so MUL_CYCLES=1 can finish at T+1.
  mc_op_e      op_s;
  logic [31:0] a_s, b_s;
  logic [63:0] base_s, a_ext, b_ext, prod, mul_res;
  logic        mul_signed;

  always_comb begin
    op_s   = op_q;
    a_s    = a_q;
    b_s    = b_q;
    base_s = hilo_q;
    if (state_q == ST_IDLE) begin
      op_s   = req.op;
      a_s    = req.reg0;
      b_s    = req.reg1;
      base_s = req.hilo;
    end
    mul_signed = (op_s == OP_MULT) || (op_s == OP_MADD) ||
                 (op_s == OP_MSUB) || (op_s == OP_MUL);
    a_ext = mul_signed ? {{32{a_s[31]}}, a_s} : {32'b0, a_s};
    b_ext = mul_signed ? {{32{b_s[31]}}, b_s} : {32'b0, b_s};
    prod  = a_ext * b_ext;
    case (op_s)
      OP_MADD, OP_MADDU: mul_res = base_s + prod;
      OP_MSUB, OP_MSUBU: mul_res = base_s - prod;
      OP_MUL:            mul_res = {base_s[63:32], prod[31:0]};
      default:           mul_res = prod;
    endcase
  end

  logic        div_signed;
  logic [31:0] a_abs, b_abs, rem_nx, quo_nx, quo_fx, rem_fx;
  logic [32:0] rem_sh;
  logic        fits;

  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_abs  = (div_signed && a_q[31]) ? (32'd0 - a_q) : a_q;
    b_abs  = (div_signed && b_q[31]) ? (32'd0 - b_q) : b_q;
    // Restoring step: shift the next dividend bit into the partial remainder.
    rem_sh = {rem_q, quo_q[31]};
    fits   = (rem_sh >= {1'b0, dvs_q});
    rem_nx = fits ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
    quo_nx = {quo_q[30:0], fits};
    quo_fx = quo_neg_q ? (32'd0 - quo_q) : quo_q;
    rem_fx = rem_neg_q ? (32'd0 - rem_q) : rem_q;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hilo_d    = hilo_q;
    result_d  = result_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    quo_neg_d = quo_neg_q;
    rem_neg_d = rem_neg_q;
    if (flush) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      result_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req.is_multicyc) begin
            op_d   = req.op;
            a_d    = req.reg0;
            b_d    = req.reg1;
            hilo_d = req.hilo;
            cnt_d  = '0;
            case (req.op)
              OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU, OP_MUL: begin
                if (MUL_CYCLES == 1) begin
                  state_d  = ST_DONE;
                  result_d = mul_res;
                end else begin
                  state_d = ST_MUL;
                end
              end
              OP_DIV, OP_DIVU: state_d = ST_DIV_PREP;
              default: begin
                state_d  = ST_DONE;
                result_d = req.hilo;
              end
            endcase
          end
        end
        ST_MUL: begin
          if (cnt_q == MUL_LAST) begin
            state_d  = ST_DONE;
            result_d = mul_res;
            cnt_d    = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_DIV_PREP: begin
          quo_d     = a_abs;
          rem_d     = '0;
          dvs_d     = b_abs;
          quo_neg_d = div_signed && (a_q[31] ^ b_q[31]);
          rem_neg_d = div_signed && a_q[31];
          cnt_d     = '0;
          state_d   = ST_DIV_ITER;
`ifdef MULTICYC_DIV_FASTPATH_EN
          if (b_q == 32'd0) begin
            state_d  = ST_DONE;
            result_d = {a_q, 32'hFFFF_FFFF};
          end else if (a_abs < b_abs) begin
            state_d  = ST_DONE;
            result_d = {a_q, 32'h0};
          end
`endif
        end
        ST_DIV_ITER: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          if (cnt_q == DIV_LAST) begin
            state_d = ST_DIV_FIX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        ST_DIV_FIX: begin
          state_d  = ST_DONE;
          result_d = {rem_fx, quo_fx};
        end
        ST_DONE: begin
          // No accept here, so a request still held by EX is not restarted.
          if (resp_ack) begin
            state_d  = ST_IDLE;
            result_d = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      op_q      <= OP_NOP;
      a_q       <= '0;
      b_q       <= '0;
      hilo_q    <= '0;
      result_q  <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      quo_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hilo_q    <= hilo_d;
      result_q  <= result_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      quo_neg_q <= quo_neg_d;
      rem_neg_q <= rem_neg_d;
    end
  end

  always_comb begin
    resp.valid = (state_q == ST_DONE);
    resp.ready = (state_q == ST_DONE);
    resp.hilo  = result_q;
    busy       = (state_q != ST_IDLE);
  end

endmodule
